// File: rtl/mem_phase_ctrl.sv
// mem_phase_ctrl: sequences UART load, processor run and UART dump over one shared single-port BRAM
module mem_phase_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_done_tick,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              tx_done_tick,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   input  logic              proc_done,
   output logic              p_enable,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [DATA_W-1:0] proc_din,
   input  logic              proc_wea,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_wea,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [1:0]        phase
);
   typedef enum logic [2:0] {LOAD, RUN, DUMP_RD, DUMP_LAT, DUMP_TX, DONE} state_t;
   state_t state;
   logic [ADDR_W-1:0] cnt;
   logic last;
   assign last = &cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= LOAD;
         cnt      <= '0;
         p_enable <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            LOAD: if (rx_done_tick) begin
               cnt <= last ? '0 : cnt + ADDR_W'(1);
               if (last) begin
                  state    <= RUN;
                  p_enable <= 1'b1;
               end
            end
            RUN: if (proc_done) begin
               p_enable <= 1'b0;
               cnt      <= '0;
               state    <= DUMP_RD;
            end
            DUMP_RD: state <= DUMP_LAT;
            DUMP_LAT: begin
               tx_data  <= mem_dout;
               tx_start <= 1'b1;
               state    <= DUMP_TX;
            end
            // a done tick during our own tx_start cycle belongs to the previous byte
            DUMP_TX: if (tx_done_tick && !tx_start) begin
               cnt   <= last ? '0 : cnt + ADDR_W'(1);
               state <= last ? DONE : DUMP_RD;
            end
            DONE: state <= DONE;
            default: state <= LOAD;
         endcase
      end
   always_comb begin
      mem_addr = state == RUN ? proc_addr : state == DONE ? '0 : cnt;
      mem_din  = state == RUN ? proc_din : state == LOAD ? rx_data : '0;
      mem_wea  = state == RUN ? proc_wea : state == LOAD && rx_done_tick;
      phase    = state == LOAD ? 2'd0 : state == RUN ? 2'd1 : state == DONE ? 2'd3 : 2'd2;
   end
endmodule

// File: tb/tb_mem_phase_ctrl.sv
// tb_mem_phase_ctrl: directed checks of load, run mux, dump sequencing and async reset (ADDR_W=4)
module tb_mem_phase_ctrl;
   logic clk = 1'b0, rst = 1'b0;
   logic rx_done_tick = 1'b0, tx_done_tick = 1'b0, proc_done = 1'b0, proc_wea = 1'b0;
   logic [7:0] rx_data = '0, proc_din = '0, tx_data, mem_din, mem_dout;
   logic [3:0] proc_addr = '0, mem_addr;
   logic tx_start, p_enable, mem_wea;
   logic [1:0] phase;
   logic [7:0] ram [16];
   logic [7:0] exp_mem [16];
   int n_checks = 0, n_fail = 0;

   mem_phase_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
      .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data),
      .proc_done(proc_done), .p_enable(p_enable), .proc_addr(proc_addr),
      .proc_din(proc_din), .proc_wea(proc_wea), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_wea(mem_wea), .mem_dout(mem_dout), .phase(phase)
   );

   always #5 clk = ~clk;

   // synchronous-read BRAM, read-before-write
   always @(posedge clk) begin
      if (mem_wea) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   task automatic test_reset;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (phase !== 2'd0 || p_enable !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || mem_wea !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: phase=%0d p_enable=%b tx_start=%b tx_data=%h mem_wea=%b, want 0 0 0 00 0",
                  phase, p_enable, tx_start, tx_data, mem_wea);
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_load(input logic [7:0] base, input int gap);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rx_done_tick = 1'b1; rx_data = base + 8'(i);
         proc_done = 1'b0; tx_done_tick = 1'b0; proc_wea = 1'b0;
         exp_mem[i] = base + 8'(i);
         #1;
         n_checks++;
         if (mem_addr !== 4'(i) || mem_din !== base + 8'(i) || mem_wea !== 1'b1 || phase !== 2'd0) begin
            n_fail++;
            $display("FAIL load_write[%0d]: addr=%0d din=%h wea=%b phase=%0d, want %0d %h 1 0",
                     i, mem_addr, mem_din, mem_wea, phase, i, base + 8'(i));
         end
         if (i < 15)
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               rx_done_tick = 1'b0; proc_done = 1'b1; tx_done_tick = 1'b1; proc_wea = 1'b1;
               #1;
               n_checks++;
               if (mem_wea !== 1'b0 || phase !== 2'd0 || p_enable !== 1'b0 || tx_start !== 1'b0) begin
                  n_fail++;
                  $display("FAIL load_idle[%0d]: wea=%b phase=%0d p_enable=%b tx_start=%b, want 0 0 0 0",
                           i, mem_wea, phase, p_enable, tx_start);
               end
            end
      end
      @(negedge clk);
      rx_done_tick = 1'b0; proc_done = 1'b0; tx_done_tick = 1'b0; proc_wea = 1'b0;
      #1;
      n_checks++;
      if (phase !== 2'd1 || p_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL load_to_run: phase=%0d p_enable=%b, want 1 1", phase, p_enable);
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (ram[i] !== base + 8'(i)) begin
            n_fail++;
            $display("FAIL load_ram[%0d]: got %h, want %h", i, ram[i], base + 8'(i));
         end
      end
   endtask

   task automatic test_back_to_back;
      test_load(8'hA0, 0);
   endtask

   task automatic test_run_mux;
      @(negedge clk);
      proc_addr = 4'h5; proc_din = 8'hAA; proc_wea = 1'b1; rx_done_tick = 1'b1; rx_data = 8'h55;
      #1;
      n_checks++;
      if (mem_addr !== 4'h5 || mem_din !== 8'hAA || mem_wea !== 1'b1 || phase !== 2'd1 || p_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL run_mux_write: addr=%h din=%h wea=%b phase=%0d p_enable=%b, want 5 aa 1 1 1",
                  mem_addr, mem_din, mem_wea, phase, p_enable);
      end
      exp_mem[5] = 8'hAA;
      @(negedge clk);
      proc_addr = 4'h3; proc_din = 8'h66; proc_wea = 1'b0;
      #1;
      n_checks++;
      if (mem_addr !== 4'h3 || mem_din !== 8'h66 || mem_wea !== 1'b0) begin
         n_fail++;
         $display("FAIL run_mux_read: addr=%h din=%h wea=%b, want 3 66 0", mem_addr, mem_din, mem_wea);
      end
      @(negedge clk);
      rx_done_tick = 1'b0; proc_addr = '0; proc_din = '0;
      n_checks++;
      if (ram[5] !== 8'hAA || ram[3] !== exp_mem[3]) begin
         n_fail++;
         $display("FAIL run_ram: ram5=%h ram3=%h, want aa %h", ram[5], ram[3], exp_mem[3]);
      end
   endtask

   task automatic test_dump(input int stop_at);
      @(negedge clk) proc_done = 1'b1;
      @(posedge clk) #1;
      proc_done = 1'b0;
      n_checks++;
      if (phase !== 2'd2 || p_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL dump_entry: phase=%0d p_enable=%b, want 2 0", phase, p_enable);
      end
      for (int k = 0; k < 16; k++) begin
         n_checks++;
         if (mem_addr !== 4'(k) || mem_wea !== 1'b0 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_rd[%0d]: addr=%0d wea=%b tx_start=%b, want %0d 0 0", k, mem_addr, mem_wea, tx_start, k);
         end
         @(posedge clk) #1;
         n_checks++;
         if (tx_start !== 1'b0 || phase !== 2'd2) begin
            n_fail++;
            $display("FAIL dump_lat[%0d]: tx_start=%b phase=%0d, want 0 2", k, tx_start, phase);
         end
         @(posedge clk) #1;
         n_checks++;
         if (tx_start !== 1'b1 || tx_data !== exp_mem[k]) begin
            n_fail++;
            $display("FAIL dump_tx[%0d]: tx_start=%b tx_data=%h, want 1 %h", k, tx_start, tx_data, exp_mem[k]);
         end
         if (k == stop_at) begin
            #2 rst = 1'b1;
            #1;
            n_checks++;
            if (phase !== 2'd0 || tx_start !== 1'b0 || p_enable !== 1'b0 || tx_data !== 8'h00 || mem_wea !== 1'b0) begin
               n_fail++;
               $display("FAIL dump_abort: phase=%0d tx_start=%b p_enable=%b tx_data=%h wea=%b, want 0 0 0 00 0",
                        phase, tx_start, p_enable, tx_data, mem_wea);
            end
            @(negedge clk) rst = 1'b0;
            return;
         end
         tx_done_tick = 1'b1;
         @(posedge clk) #1;
         tx_done_tick = 1'b0;
         n_checks++;
         if (tx_start !== 1'b0 || phase !== 2'd2 || mem_addr !== 4'(k)) begin
            n_fail++;
            $display("FAIL dump_stale[%0d]: tx_start=%b phase=%0d addr=%0d, want 0 2 %0d", k, tx_start, phase, mem_addr, k);
         end
         @(posedge clk) #1;
         tx_done_tick = 1'b1;
         @(posedge clk) #1;
         tx_done_tick = 1'b0;
      end
      n_checks++;
      if (phase !== 2'd3 || tx_start !== 1'b0 || mem_addr !== 4'h0 || mem_wea !== 1'b0 || p_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL dump_done: phase=%0d tx_start=%b addr=%0d wea=%b p_enable=%b, want 3 0 0 0 0",
                  phase, tx_start, mem_addr, mem_wea, p_enable);
      end
      rx_done_tick = 1'b1; proc_done = 1'b1; tx_done_tick = 1'b1; proc_wea = 1'b1; proc_addr = 4'h9;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk) #1;
         n_checks++;
         if (phase !== 2'd3 || tx_start !== 1'b0 || mem_wea !== 1'b0 || mem_addr !== 4'h0 || p_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold[%0d]: phase=%0d tx_start=%b wea=%b addr=%0d p_enable=%b, want 3 0 0 0 0",
                     c, phase, tx_start, mem_wea, mem_addr, p_enable);
         end
      end
      rx_done_tick = 1'b0; proc_done = 1'b0; tx_done_tick = 1'b0; proc_wea = 1'b0; proc_addr = '0;
   endtask

   task automatic test_reset_recovery;
      @(negedge clk);
      rx_done_tick = 1'b1; rx_data = 8'h77;
      #1;
      n_checks++;
      if (mem_addr !== 4'h0 || mem_wea !== 1'b1 || phase !== 2'd0) begin
         n_fail++;
         $display("FAIL recovery_write: addr=%0d wea=%b phase=%0d, want 0 1 0", mem_addr, mem_wea, phase);
      end
      @(negedge clk) rx_done_tick = 1'b0;
      #1;
      n_checks++;
      if (ram[0] !== 8'h77 || mem_addr !== 4'h1) begin
         n_fail++;
         $display("FAIL recovery_ram: ram0=%h addr=%0d, want 77 1", ram[0], mem_addr);
      end
   endtask

   initial begin
      test_reset;
      test_load(8'h10, 2);
      test_run_mux;
      test_dump(16);
      test_reset;
      test_back_to_back;
      test_dump(7);
      test_reset_recovery;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
